// File: rtl/grf_read_scoreboard_pkg.sv
// Shared constants for the GRF read scoreboard.
// Register-index width, zero register and default sizes.
package grf_read_scoreboard_pkg;

  localparam int REG_W  = 5;
  localparam int NREG   = 32;
  localparam int CNT_W  = 2;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/grf_pending_cnt.sv
// Per-register pending-writer counter with error detection.
// Ports: inc/dec_ret/dec_kill events in; cnt_q, next-nonzero, err out.
module grf_pending_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec_ret,
  input  logic             dec_kill,
  output logic [CNT_W-1:0] cnt_q,
  output logic             nz_d,
  output logic             err
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   up;
  logic [CNT_W:0]   dn;
  logic [CNT_W:0]   net;

  // One extra bit catches both overflow and underflow of the net delta.
  always_comb begin
    up    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
    dn    = {{CNT_W{1'b0}}, dec_ret} + {{CNT_W{1'b0}}, dec_kill};
    net   = up - dn;
    err   = (up < dn) || net[CNT_W];
    cnt_d = err ? cnt_q : net[CNT_W-1:0];
    nz_d  = |cnt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/grf_read_scoreboard.sv
// D-stage read scoreboard: stall on pending writers, W write-through bypass.
// Ports: rs/rt reads, issue/retire/kill events; stall_D, rd1/rd2, busy, err.
module grf_read_scoreboard
  import grf_read_scoreboard_pkg::*;
#(
  parameter int NREG   = grf_read_scoreboard_pkg::NREG,
  parameter int CNT_W  = grf_read_scoreboard_pkg::CNT_W,
  parameter int DATA_W = grf_read_scoreboard_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  rs_D,
  input  logic [REG_W-1:0]  rt_D,
  input  logic              use_rs_D,
  input  logic              use_rt_D,
  input  logic [DATA_W-1:0] grf_rd1,
  input  logic [DATA_W-1:0] grf_rd2,
  input  logic              issue_en,
  input  logic [REG_W-1:0]  issue_dst,
  input  logic              regwrite_W,
  input  logic [REG_W-1:0]  dst_W,
  input  logic [DATA_W-1:0] wdata_W,
  input  logic              kill_en,
  input  logic [REG_W-1:0]  kill_dst,
  output logic              stall_D,
  output logic [DATA_W-1:0] rd1_D,
  output logic [DATA_W-1:0] rd2_D,
  output logic              busy_any,
  output logic              overflow_err
);

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            ret_hit;
  logic [NREG-1:0]            nz_d;
  logic [NREG-1:0]            err_v;
  logic                       iss;
  logic                       blk_rs;
  logic                       blk_rt;
  logic                       busy_any_d;
  logic                       busy_any_q;
  logic                       overflow_err_d;
  logic                       overflow_err_q;

  assign cnt[0]     = '0;
  assign ret_hit[0] = 1'b0;
  assign nz_d[0]    = 1'b0;
  assign err_v[0]   = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    localparam logic [REG_W-1:0] RI = REG_W'(r);
    assign ret_hit[r] = regwrite_W && (dst_W == RI);
    grf_pending_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (iss && (issue_dst == RI)),
      .dec_ret  (ret_hit[r]),
      .dec_kill (kill_en && (kill_dst == RI)),
      .cnt_q    (cnt[r]),
      .nz_d     (nz_d[r]),
      .err      (err_v[r])
    );
  end

  // A lone writer retiring this cycle is covered by the bypass mux.
  always_comb begin
    blk_rs = use_rs_D && (rs_D != REG_ZERO)
          && (cnt[rs_D] != '0)
          && !((cnt[rs_D] == CNT_W'(1)) && ret_hit[rs_D]);
    blk_rt = use_rt_D && (rt_D != REG_ZERO)
          && (cnt[rt_D] != '0)
          && !((cnt[rt_D] == CNT_W'(1)) && ret_hit[rt_D]);
    stall_D = blk_rs || blk_rt;
    iss     = issue_en && !stall_D && (issue_dst != REG_ZERO);
  end

  always_comb begin
    rd1_D = grf_rd1;
    rd2_D = grf_rd2;
    if (rs_D == REG_ZERO)  rd1_D = '0;
    else if (ret_hit[rs_D]) rd1_D = wdata_W;
    if (rt_D == REG_ZERO)  rd2_D = '0;
    else if (ret_hit[rt_D]) rd2_D = wdata_W;
  end

  always_comb begin
    busy_any_d     = |nz_d;
    overflow_err_d = overflow_err_q || (|err_v);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_any_q     <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      busy_any_q     <= busy_any_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  assign busy_any     = busy_any_q;
  assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_grf_read_scoreboard.sv
// Testbench for grf_read_scoreboard: directed vector table,
// a reset-mid-flight sequence and randomized model comparison.
module tb_grf_read_scoreboard;

  localparam logic [31:0] GA = 32'hAAAA0001;
  localparam logic [31:0] GB = 32'hBBBB0002;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, issue_dst, dst_W, kill_dst;
  logic        use_rs_D, use_rt_D, issue_en, regwrite_W, kill_en;
  logic [31:0] grf_rd1, grf_rd2, wdata_W;
  logic        stall_D, busy_any, overflow_err;
  logic [31:0] rd1_D, rd2_D;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  grf_read_scoreboard dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D),
    .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .grf_rd1(grf_rd1), .grf_rd2(grf_rd2),
    .issue_en(issue_en), .issue_dst(issue_dst),
    .regwrite_W(regwrite_W), .dst_W(dst_W),
    .wdata_W(wdata_W),
    .kill_en(kill_en), .kill_dst(kill_dst),
    .stall_D(stall_D), .rd1_D(rd1_D), .rd2_D(rd2_D),
    .busy_any(busy_any), .overflow_err(overflow_err)
  );

  typedef struct {
    logic rst;
    logic [4:0] rs; logic urs;
    logic [4:0] rt; logic urt;
    logic ie; logic [4:0] idst;
    logic rw; logic [4:0] dw; logic [31:0] wd;
    logic ke; logic [4:0] kd;
    logic es; logic [31:0] e1; logic [31:0] e2;
    logic eb; logic ee;
  } vec_t;

  function automatic vec_t mk(
    logic rst, logic [4:0] rs, logic urs, logic [4:0] rt, logic urt,
    logic ie, logic [4:0] idst, logic rw, logic [4:0] dw,
    logic [31:0] wd, logic ke, logic [4:0] kd,
    logic es, logic [31:0] e1, logic [31:0] e2, logic eb, logic ee);
    vec_t v;
    v.rst = rst; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
    v.ie = ie; v.idst = idst; v.rw = rw; v.dw = dw; v.wd = wd;
    v.ke = ke; v.kd = kd; v.es = es; v.e1 = e1; v.e2 = e2;
    v.eb = eb; v.ee = ee;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic rst, input logic [4:0] rs,
    input logic urs, input logic [4:0] rt, input logic urt,
    input logic ie, input logic [4:0] idst, input logic rw,
    input logic [4:0] dw, input logic [31:0] wd, input logic ke,
    input logic [4:0] kd);
    reset = rst; rs_D = rs; use_rs_D = urs; rt_D = rt; use_rt_D = urt;
    issue_en = ie; issue_dst = idst; regwrite_W = rw; dst_W = dw;
    wdata_W = wd; kill_en = ke; kill_dst = kd;
  endtask

  // Called at posedge+1 with inputs applied; returns at next posedge+1.
  task automatic tick_check(input string tag, input logic es,
    input logic [31:0] e1, input logic [31:0] e2,
    input logic eb, input logic ee);
    #2;
    check({tag, " stall_D"}, {31'd0, stall_D}, {31'd0, es});
    check({tag, " rd1_D"}, rd1_D, e1);
    check({tag, " rd2_D"}, rd2_D, e2);
    @(posedge clk); #1;
    check({tag, " busy_any"}, {31'd0, busy_any}, {31'd0, eb});
    check({tag, " overflow_err"}, {31'd0, overflow_err}, {31'd0, ee});
  endtask

  vec_t tbl[$];

  // Reference model: plain per-register pending counts.
  int   mc[32];
  logic merr;

  initial begin
    grf_rd1 = GA; grf_rd2 = GB;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back(mk(0,5,1,1,0, 0,0, 0,0,0, 0,0, 0,GA,GB,0,0));
    tbl.push_back(mk(0,5,1,1,0, 1,8, 0,0,0, 0,0, 0,GA,GB,1,0));
    tbl.push_back(mk(0,8,1,1,0, 0,0, 0,0,0, 0,0, 1,GA,GB,1,0));
    tbl.push_back(mk(0,8,1,1,0, 0,0, 1,8,32'hDEADBEEF, 0,0,
                     0,32'hDEADBEEF,GB,0,0));
    tbl.push_back(mk(0,5,1,1,0, 1,3, 0,0,0, 0,0, 0,GA,GB,1,0));
    tbl.push_back(mk(0,5,1,1,0, 1,3, 0,0,0, 0,0, 0,GA,GB,1,0));
    tbl.push_back(mk(0,5,1,3,1, 0,0, 1,3,32'h11111111, 0,0,
                     1,GA,32'h11111111,1,0));
    tbl.push_back(mk(0,5,1,3,1, 0,0, 1,3,32'h22222222, 0,0,
                     0,GA,32'h22222222,0,0));
    tbl.push_back(mk(0,0,1,1,0, 1,0, 1,0,32'h1234, 0,0, 0,0,GB,0,0));
    tbl.push_back(mk(0,5,1,1,0, 1,9, 0,0,0, 0,0, 0,GA,GB,1,0));
    tbl.push_back(mk(0,5,1,1,0, 1,9, 0,0,0, 0,0, 0,GA,GB,1,0));
    tbl.push_back(mk(0,5,1,1,0, 1,9, 1,9,32'h99, 1,9, 0,GA,GB,1,0));
    tbl.push_back(mk(0,5,1,1,0, 0,0, 1,9,32'h98, 0,0, 0,GA,GB,0,0));
    tbl.push_back(mk(0,5,1,1,0, 0,0, 0,0,0, 1,9, 0,GA,GB,0,1));
    tbl.push_back(mk(0,5,1,1,0, 0,0, 0,0,0, 0,0, 0,GA,GB,0,1));
    tbl.push_back(mk(0,5,1,1,0, 1,4, 0,0,0, 0,0, 0,GA,GB,1,1));
    tbl.push_back(mk(0,4,1,1,0, 1,6, 0,0,0, 0,0, 1,GA,GB,1,1));
    tbl.push_back(mk(0,4,1,1,0, 0,0, 1,4,32'h44, 0,0, 0,32'h44,GB,0,1));
    tbl.push_back(mk(1,5,1,1,0, 1,7, 0,0,0, 0,0, 0,GA,GB,0,0));
    tbl.push_back(mk(0,5,1,1,0, 1,7, 0,0,0, 0,0, 0,GA,GB,1,0));
    tbl.push_back(mk(0,5,1,1,0, 1,7, 0,0,0, 0,0, 0,GA,GB,1,0));
    tbl.push_back(mk(0,5,1,1,0, 1,7, 0,0,0, 0,0, 0,GA,GB,1,0));
    tbl.push_back(mk(0,5,1,1,0, 1,7, 0,0,0, 0,0, 0,GA,GB,1,1));
    tbl.push_back(mk(0,7,1,1,0, 0,0, 1,7,32'h77, 0,0, 1,32'h77,GB,1,1));
    tbl.push_back(mk(1,5,1,1,0, 0,0, 0,0,0, 0,0, 0,GA,GB,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.rs, v.urs, v.rt, v.urt, v.ie, v.idst,
            v.rw, v.dw, v.wd, v.ke, v.kd);
      tick_check($sformatf("vec%0d", i), v.es, v.e1, v.e2, v.eb, v.ee);
    end

    // Reset mid-flight drops pending writers on $10.
    drive(0, 5,1,1,0, 1,10, 0,0,0, 0,0);
    tick_check("mid issue1", 0, GA, GB, 1, 0);
    drive(0, 5,1,1,0, 1,10, 0,0,0, 0,0);
    tick_check("mid issue2", 0, GA, GB, 1, 0);
    drive(0, 10,1,10,1, 0,0, 0,0,0, 0,0);
    tick_check("mid pending", 1, GA, GB, 1, 0);
    drive(1, 10,1,10,1, 0,0, 0,0,0, 0,0);
    tick_check("mid reset", 1, GA, GB, 0, 0);
    drive(0, 10,1,10,1, 0,0, 0,0,0, 0,0);
    tick_check("mid after", 0, GA, GB, 0, 0);

    // Randomized phase against the reference model.
    foreach (mc[r]) mc[r] = 0;
    merr = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        rst, urs, urt, ie, rw, ke, es, blk1, blk2, iss, eb;
      logic [4:0]  rs, rt, idst, dw, kd;
      logic [31:0] wd, e1, e2;
      int          nc[32];
      rst  = ($urandom_range(0, 99) == 0);
      rs   = 5'($urandom_range(0, 7));
      rt   = 5'($urandom_range(0, 7));
      urs  = 1'($urandom);
      urt  = 1'($urandom);
      ie   = ($urandom_range(0, 2) != 0);
      idst = 5'($urandom_range(0, 7));
      dw   = 5'($urandom_range(0, 7));
      rw   = ($urandom_range(0, 1) == 0) &&
             (mc[dw] > 0 || $urandom_range(0, 15) == 0);
      kd   = 5'($urandom_range(0, 7));
      ke   = ($urandom_range(0, 15) == 0) &&
             (mc[kd] > 0 || $urandom_range(0, 3) == 0);
      wd   = $urandom;
      grf_rd1 = $urandom;
      grf_rd2 = $urandom;
      drive(rst, rs, urs, rt, urt, ie, idst, rw, dw, wd, ke, kd);

      e1 = (rs == 0) ? 32'd0 : ((rw && dw == rs) ? wd : grf_rd1);
      e2 = (rt == 0) ? 32'd0 : ((rw && dw == rt) ? wd : grf_rd2);
      blk1 = urs && rs != 0 && mc[rs] != 0 &&
             !(mc[rs] == 1 && rw && dw == rs);
      blk2 = urt && rt != 0 && mc[rt] != 0 &&
             !(mc[rt] == 1 && rw && dw == rt);
      es  = blk1 || blk2;
      iss = ie && !es && idst != 0;

      eb = 1'b0;
      for (int r = 0; r < 32; r++) begin
        int n;
        n = mc[r];
        if (r != 0) begin
          n = mc[r] + ((iss && idst == r) ? 1 : 0)
                    - ((rw && dw == r) ? 1 : 0)
                    - ((ke && kd == r) ? 1 : 0);
          if (n < 0 || n > 3) begin
            merr = 1'b1;
            n = mc[r];
          end
        end
        nc[r] = rst ? 0 : n;
        if (nc[r] != 0) eb = 1'b1;
      end
      if (rst) merr = 1'b0;

      tick_check($sformatf("rnd%0d", cyc), es, e1, e2, eb, merr);
      foreach (mc[r]) mc[r] = nc[r];
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
